// File: rtl/uop_sequencer_pkg.sv
// Shared types and default configuration for the uop sequencer.
// Contents:
//   Def*         default configuration constants
//   seq_state_e  sequencer FSM state
//   uop_bundle_t one queued bundle at the default configuration
package uop_sequencer_pkg;

  localparam int unsigned DefFetchWidth = 2;
  localparam int unsigned DefInstrBits  = 32;
  localparam int unsigned DefUopBufSize = 64;
  localparam int unsigned DefQueueDepth = 4;
  localparam int unsigned DefAddrBits   = $clog2(DefUopBufSize);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } seq_state_e;

  typedef struct packed {
    logic [DefFetchWidth-1:0]                   lane_valid;
    logic [DefFetchWidth-1:0][DefInstrBits-1:0] instr;
    logic [DefAddrBits-1:0]                     pc;
  } uop_bundle_t;

endpackage

// File: rtl/uop_sequencer_bundle_fifo.sv
// Circular bundle FIFO with head/tail pointers and an explicit occupancy count.
// Ports:
//   i_clk, i_reset  clock, synchronous active-high reset
//   i_push, i_data  write one entry (dropped when full and not popping)
//   i_pop           remove head entry (ignored when empty)
//   i_flush         empty the FIFO; overrides same-cycle push and pop
//   o_data, o_valid head entry (zero when empty) and non-empty flag
//   o_count         occupied entries
module uop_bundle_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [Width-1:0]       i_data,
  output logic [Width-1:0]       o_data,
  output logic                   o_valid,
  output logic [$clog2(Depth):0] o_count
);

  localparam int unsigned PtrBits = $clog2(Depth);
  localparam int unsigned CntBits = PtrBits + 1;

  logic [Width-1:0]   r_mem [Depth];
  logic [PtrBits-1:0] r_head, r_tail;
  logic [CntBits-1:0] r_count, w_count_next;
  logic               w_pop_eff, w_push_eff;

  assign w_pop_eff  = i_pop && (r_count != '0);
  assign w_push_eff = i_push && ((r_count != CntBits'(Depth)) || w_pop_eff);

  always_comb begin
    w_count_next = r_count;
    unique case ({w_push_eff, w_pop_eff})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_eff) r_tail <= r_tail + 1'b1;
      if (w_pop_eff)  r_head <= r_head + 1'b1;
      r_count <= w_count_next;
    end
  end

  // Storage needs no reset: the head is masked to zero while the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (w_push_eff && !i_flush) r_mem[r_tail] <= i_data;
  end

  assign o_valid = (r_count != '0);
  assign o_data  = o_valid ? r_mem[r_head] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/uop_sequencer.sv
// Microcode fetch front end: sequences FETCH_WIDTH-wide uop bundles from the
// uop buffer starting at i_start_addr until a lane flags end-of-sequence, and
// hands them to decode through a flushable bundle queue.
// Ports:
//   i_clk, i_reset                     clock, synchronous active-high reset
//   i_start, i_start_addr              begin a sequence (idle only)
//   i_clear                            abort sequence, flush queue
//   i_redirect, i_redirect_addr        jump while busy, flush queue
//   o_uop_addr, i_uop_data, i_uop_last buffer read port (lane 0 address)
//   i_next_stalled                     decode back-pressure
//   o_out_*                            queue head bundle
//   o_queue_count, o_busy              status
//   o_perf_stall_cycles, o_perf_bundles counters, present only when the
//                                      UOP_SEQ_PERF_EN macro is defined
module uop_sequencer
  import uop_sequencer_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH  = DefFetchWidth,
  parameter int unsigned INSTR_BITS   = DefInstrBits,
  parameter int unsigned UOP_BUF_SIZE = DefUopBufSize,
  parameter int unsigned QUEUE_DEPTH  = DefQueueDepth
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic                              i_start,
  input  logic [$clog2(UOP_BUF_SIZE)-1:0]   i_start_addr,
  input  logic                              i_clear,
  input  logic                              i_redirect,
  input  logic [$clog2(UOP_BUF_SIZE)-1:0]   i_redirect_addr,
  output logic [$clog2(UOP_BUF_SIZE)-1:0]   o_uop_addr,
  input  logic [FETCH_WIDTH*INSTR_BITS-1:0] i_uop_data,
  input  logic [FETCH_WIDTH-1:0]            i_uop_last,
  input  logic                              i_next_stalled,
  output logic                              o_out_valid,
  output logic [FETCH_WIDTH-1:0]            o_out_lane_valid,
  output logic [FETCH_WIDTH*INSTR_BITS-1:0] o_out_instr,
  output logic [$clog2(UOP_BUF_SIZE)-1:0]   o_out_pc,
  output logic [$clog2(QUEUE_DEPTH):0]      o_queue_count,
  output logic                              o_busy,
  output logic [31:0]                       o_perf_stall_cycles,
  output logic [31:0]                       o_perf_bundles
);

  localparam int unsigned ADDR_BITS  = $clog2(UOP_BUF_SIZE);
  localparam int unsigned CNT_BITS   = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned DATA_BITS  = FETCH_WIDTH * INSTR_BITS;
  localparam int unsigned ENTRY_BITS = FETCH_WIDTH + DATA_BITS + ADDR_BITS;

  seq_state_e             r_state, w_state_next;
  logic [ADDR_BITS-1:0]   r_pc, w_pc_next;

  logic [CNT_BITS-1:0]    w_count;
  logic                   w_head_valid;
  logic [ENTRY_BITS-1:0]  w_head, w_push_data;
  logic                   w_pop, w_can_accept, w_fetch, w_any_last;
  logic                   w_redirect_take, w_flush;
  logic [FETCH_WIDTH-1:0] w_mask;
  logic                   w_seen_last;

  assign w_pop           = w_head_valid && !i_next_stalled;
  // A full queue can still take a bundle when the head leaves this cycle.
  assign w_can_accept    = (w_count < CNT_BITS'(QUEUE_DEPTH)) || w_pop;
  assign w_any_last      = |i_uop_last;
  assign w_redirect_take = i_redirect && (r_state != StIdle);
  assign w_flush         = i_clear || w_redirect_take;

  // Lanes up to and including the lowest flagged end-of-sequence lane.
  always_comb begin
    w_seen_last = 1'b0;
    w_mask      = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      w_mask[i]   = !w_seen_last;
      w_seen_last = w_seen_last | i_uop_last[i];
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_pc    <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    if (i_clear) begin
      w_state_next = StIdle;
    end else if (w_redirect_take) begin
      w_state_next = StRun;
      w_pc_next    = i_redirect_addr;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_start) begin
            w_state_next = StRun;
            w_pc_next    = i_start_addr;
          end
        end
        StRun: begin
          if (w_fetch) begin
            if (w_any_last) w_state_next = StDrain;
            else            w_pc_next    = r_pc + ADDR_BITS'(FETCH_WIDTH);
          end
        end
        StDrain: begin
          if ((w_count == '0) || ((w_count == CNT_BITS'(1)) && w_pop)) w_state_next = StIdle;
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  // Output logic
  always_comb begin
    w_fetch    = (r_state == StRun) && w_can_accept;
    o_busy     = (r_state != StIdle);
    o_uop_addr = r_pc;
  end

  assign w_push_data = {w_mask, i_uop_data, r_pc};

  uop_bundle_fifo #(
    .Width (ENTRY_BITS),
    .Depth (QUEUE_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_fetch),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (w_push_data),
    .o_data  (w_head),
    .o_valid (w_head_valid),
    .o_count (w_count)
  );

  assign o_out_valid      = w_head_valid;
  assign o_out_lane_valid = w_head[ENTRY_BITS-1 -: FETCH_WIDTH];
  assign o_out_instr      = w_head[ADDR_BITS +: DATA_BITS];
  assign o_out_pc         = w_head[ADDR_BITS-1:0];
  assign o_queue_count    = w_count;

`ifdef UOP_SEQ_PERF_EN
  logic [31:0] r_perf_stall, r_perf_bundles;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_perf_stall   <= '0;
      r_perf_bundles <= '0;
    end else begin
      if ((r_state == StRun) && !w_can_accept && (r_perf_stall != '1)) begin
        r_perf_stall <= r_perf_stall + 1'b1;
      end
      if (w_pop && (r_perf_bundles != '1)) r_perf_bundles <= r_perf_bundles + 1'b1;
    end
  end

  assign o_perf_stall_cycles = r_perf_stall;
  assign o_perf_bundles      = r_perf_bundles;
`else
  assign o_perf_stall_cycles = '0;
  assign o_perf_bundles      = '0;
`endif

endmodule
